// File: rtl/requant_out_stage_if.sv
// Valid/ready stream bundle carrying one payload word per accepted beat.
//   valid   : producer has a beat on payload
//   ready   : consumer accepts the beat this cycle when valid is also high
//   payload : beat data, W bits
// master drives valid/payload, slave drives ready.
interface requant_out_stage_if #(
  parameter int unsigned W = 64
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/requant_out_stage.sv
// Output requantizer: int32 accumulator beats (LANES per beat) are biased,
// scaled, round-shifted and saturated to int8, packed LANES per output word.
// Per-channel-group scale/bias come from an external memory with 1-cycle
// registered read latency.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : rising edge starts a frame
//   OutFeature_*      : channel groups per pixel (G), feature map side (P=side^2)
//   Shift             : rounding right-shift amount
//   s_data (slave)    : accumulator beats, lane i at payload[i*ACC_W +: ACC_W]
//   Scale_Read_Addr   : channel group of the next beat to be accepted
//   Scale_In, Bias_In : memory read data for the address of the last accept
//   m_data (master)   : int8 lanes, lane i at payload[i*8 +: 8]
//   mLast             : qualifies the final output beat of a frame
module requant_out_stage #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           OutFeature_Channel_Count_Times,
  input  logic [15:0]           OutFeature_Size,
  input  logic [SHIFT_W-1:0]    Shift,
  requant_out_stage_if.slave    s_data,
  output logic [ADDR_W-1:0]     Scale_Read_Addr,
  input  logic [LANES*8-1:0]    Scale_In,
  input  logic [LANES*16-1:0]   Bias_In,
  requant_out_stage_if.master   m_data,
  output logic                  mLast
);

  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned PROD_W = SUM_W + 9;
  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(127);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-128);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic                      start_q;
  logic [15:0]               g_q, g_d;
  logic [31:0]               p_q, p_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;

  logic                      s1_valid_q, s1_last_q, s1_fresh_q;
  logic [LANES*ACC_W-1:0]    s1_acc_q;
  logic [LANES*8-1:0]        s1_scale_q;
  logic [LANES*16-1:0]       s1_bias_q;

  logic                      m_valid_q, m_last_q;
  logic [LANES*8-1:0]        m_payload_q;

  logic                      s1_adv_c, s_ready_c, accept_c, last_beat_c;
  logic [15:0]               g_last_c;
  logic [31:0]               p_last_c;
  logic [LANES*8-1:0]        scale_c;
  logic [LANES*16-1:0]       bias_c;
  logic [LANES*8-1:0]        res_c;

  // One lane: (acc + bias) * scale, round half up, arithmetic shift, saturate.
  function automatic logic [7:0] requant_lane(input logic signed [ACC_W-1:0] acc,
                                              input logic [7:0]              scale,
                                              input logic signed [15:0]      bias,
                                              input logic [SHIFT_W-1:0]      sh);
    logic signed [SUM_W-1:0]  sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    logic signed [PROD_W-1:0] r;
    sum  = SUM_W'(acc) + SUM_W'(bias);
    prod = PROD_W'(sum) * $signed(PROD_W'({1'b0, scale}));
    rnd  = (sh == '0) ? '0 : $signed(PROD_W'(1) << (sh - SHIFT_W'(1)));
    r    = (prod + rnd) >>> sh;
    if (r > SAT_HI)      requant_lane = 8'h7F;
    else if (r < SAT_LO) requant_lane = 8'h80;
    else                 requant_lane = r[7:0];
  endfunction

  // Handshake and frame-boundary decode.
  assign s1_adv_c    = s1_valid_q && (!m_valid_q || m_data.ready);
  assign s_ready_c   = (state_q == RUN) && (!s1_valid_q || s1_adv_c);
  assign accept_c    = s_data.valid && s_ready_c;
  assign g_last_c    = OutFeature_Channel_Count_Times - 16'd1;
  assign p_last_c    = 32'(OutFeature_Size) * 32'(OutFeature_Size) - 32'd1;
  assign last_beat_c = (g_q == g_last_c) && (p_q == p_last_c);

  assign s_data.ready    = s_ready_c;
  assign m_data.valid    = m_valid_q;
  assign m_data.payload  = m_payload_q;
  assign mLast           = m_last_q;
  assign Scale_Read_Addr = addr_q;

  // Memory data is only valid on the first cycle a beat sits in S1; later
  // cycles use the copy captured then.
  assign scale_c = s1_fresh_q ? Scale_In : s1_scale_q;
  assign bias_c  = s1_fresh_q ? Bias_In  : s1_bias_q;

  // Per-lane arithmetic feeding S2.
  always_comb begin
    res_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      res_c[i*8 +: 8] = requant_lane($signed(s1_acc_q[i*ACC_W +: ACC_W]),
                                     scale_c[i*8 +: 8],
                                     $signed(bias_c[i*16 +: 16]),
                                     Shift);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      g_q     <= '0;
      p_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      g_q     <= g_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and group/pixel counters; address tracks the next beat's group.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          state_d = RUN;
          g_d     = '0;
          p_d     = '0;
          addr_d  = '0;
        end
      end
      RUN: begin
        if (accept_c) begin
          if (g_q == g_last_c) begin
            g_d = '0;
            p_d = p_q + 32'd1;
          end else begin
            g_d = g_q + 16'd1;
          end
          addr_d = ADDR_W'(g_d);
          if (last_beat_c) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !m_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // S1 (accept + parameter capture) and S2 (result) pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_fresh_q  <= 1'b0;
      s1_acc_q    <= '0;
      s1_scale_q  <= '0;
      s1_bias_q   <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_payload_q <= '0;
    end else begin
      if (accept_c) begin
        s1_valid_q <= 1'b1;
        s1_acc_q   <= s_data.payload;
        s1_last_q  <= last_beat_c;
        s1_fresh_q <= 1'b1;
      end else if (s1_adv_c) begin
        s1_valid_q <= 1'b0;
        s1_fresh_q <= 1'b0;
      end else if (s1_fresh_q) begin
        s1_scale_q <= Scale_In;
        s1_bias_q  <= Bias_In;
        s1_fresh_q <= 1'b0;
      end

      if (s1_adv_c) begin
        m_valid_q   <= 1'b1;
        m_payload_q <= res_c;
        m_last_q    <= s1_last_q;
      end else if (m_data.ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/requant_out_stage.md
Name: requant_out_stage

Overview:
- Output requantizer that sits directly downstream of the systolic array fed by Data_Generate.
- Consumes per-pixel int32 accumulator beats of 8 output channels each.
- Fetches per-channel scale/bias from the external Scale_Bias memory, using the same addressing style as Data_Generate.
- Emits saturated int8 activations packed 8 per 64-bit word (the same width as the input image words), and flags the last beat of the frame.

Parameters:
- LANES, 8, channels per beat.
- ACC_W, 32, signed accumulator width per lane.
- ADDR_W, 9, scale/bias memory address width (depth ≤ 512 groups).
- SHIFT_W, 5, width of runtime shift amount.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; rising edge begins a frame.
- OutFeature_Channel_Count_Times  in  16  channel groups per pixel (768/8 = 96).
- OutFeature_Size  in  16  output feature map side (14).
- Shift  in  SHIFT_W  right-shift amount, 1..31.
- sData_valid  in  1  accumulator beat valid.
- sData_ready  out  1  accumulator beat accepted when valid&ready.
- sData_payload  in  LANES*ACC_W  lane i at bits [i*32+:32], signed.
- Scale_Read_Addr  out  ADDR_W  channel-group index for the parameter memory.
- Scale_In  in  LANES*8  unsigned scale per lane; registered memory output, 1-cycle read latency.
- Bias_In  in  LANES*16  signed bias per lane, same timing as Scale_In.
- mData_valid  out  1  output valid.
- mData_ready  in  1  downstream ready.
- mData_payload  out  LANES*8  int8 lane i at bits [i*8+:8].
- mLast  out  1  high with the final output beat of a frame.

Behaviour:
- Reset: sData_ready=0, mData_valid=0, mLast=0, mData_payload=0, Scale_Read_Addr=0; group/pixel counters=0; state IDLE.
- States:
  - IDLE: sData_ready=0. A rising edge of start (start=1, previous start=0) → RUN, clearing the group counter g and the pixel counter p.
  - RUN: accepts beats. On the last accepted beat (g=G-1 and p=P-1, where G=OutFeature_Channel_Count_Times and P=OutFeature_Size²) → DRAIN.
  - DRAIN: sData_ready=0. When the pipeline is empty → IDLE.
- Beat order: pixel-major, group-minor. Each accepted beat increments g; when g wraps G-1→0, p increments. A frame is G*P beats (96*196 = 18816).
- Scale_Read_Addr is a register equal to the g of the next beat to be accepted.
  - Parameters for a beat are the Scale_In/Bias_In values presented the cycle after that beat's acceptance.
  - They must be captured then, so a downstream stall does not misalign them with subsequent addresses.
- Pipeline: 2 register stages (S1 = accept + parameter capture, S2 = arithmetic result).
  - Latency: acceptance at cycle t → mData_valid at t+2 with no stall.
  - Throughput: 1 beat/cycle while mData_ready=1.
- Handshake:
  - sData_ready=1 in RUN only when S1 is empty or S1 advances this cycle.
  - mData_valid/payload/mLast hold stable while mData_valid & !mData_ready.
  - Pipeline stalls fully on backpressure; no beat is dropped or duplicated.
- Per lane arithmetic:
  - sum = acc + sign-extend(bias), 33-bit.
  - prod = sum * zero-extend(scale), 42-bit signed.
  - r = (prod + 2^(Shift-1)) >>> Shift, arithmetic.
  - out = saturate(r, -128, 127).
- mLast asserts on the output beat originating from beat index G*P-1 only.
- start falling mid-frame is ignored. A new rising edge while not IDLE is ignored.
- reset mid-frame: everything returns to reset values next cycle, and pipeline contents are discarded.
- Scale_Read_Addr wraps to 0 after G-1.
- Scale=0 yields output 0 regardless of acc.

Test Plan:
- Reset, G=2, P=1, Shift=4, all scales=16, bias=0, acc lanes 0..7 = {0,1,-1,127,128,-129,1000,-1000} → outputs {0,1,-1,127,127,-128,127,-128}, mLast on the 2nd beat, first mData_valid 2 cycles after first accept.
- Rounding: scale=1, bias=0, Shift=1, acc {1,3,-1,-3,2} → {1,2,0,-1,1} (round-half-up before arithmetic shift).
- Bias/group alignment: G=96, P=196, memory[g] scale=1, bias=g, acc=0, Shift=1, continuous valid/ready → 18816 outputs, each lane = round(g/2), Scale_Read_Addr wraps 95→0 every pixel, mLast only on beat 18816.
- Backpressure: mData_ready toggled pseudo-randomly (50%), sData_valid gapped as in the 64-of-513-cycle pattern → output stream bit-identical to the no-stall run; payload stable during stalls.
- Start semantics: hold start=1 after frame end → no second frame; drop and re-raise start → new frame with counters from 0.
- Reset asserted at beat 500 of a frame → next cycle all outputs at reset values; a subsequent start produces a correct full frame.
